// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Purpose:
//   Turns four raw, bouncy push-button pins into clean per-button levels and
//   one-cycle press/release event pulses. The levels feed the bottom button
//   bar renderer and the game logic alike.
//   Bit mapping: bit0 = right, bit1 = left, bit2 = up/flap, bit3 = spare.
//
//   Each button goes through:
//     * a 2-flop synchroniser,
//     * normalisation to "pressed = 1" (ACTIVE_LOW selects pin polarity),
//     * a 4-state debounce FSM (IDLE, DB_PRESS, HELD, DB_RELEASE) with its
//       own counter. A level change is accepted after DEBOUNCE_CYCLES stable
//       synchronised cycles.
//
// Optional feature (compile-time macro BTN_AUTO_REPEAT_EN):
//   When defined, a held button re-issues btn_press after REPEAT_DELAY held
//   cycles and then every REPEAT_PERIOD cycles. The repeat counter freezes
//   while a release is being debounced and resumes if the release bounces back.
//   When undefined, no repeat logic exists and each accepted press gives
//   exactly one btn_press pulse.
//
// Ports:
//   clk          in   1  system clock
//   rst          in   1  synchronous active-high reset
//   key_raw      in   4  asynchronous raw button pins
//   btn_state    out  4  debounced level, 1 = held (registered)
//   btn_press    out  4  one-cycle pulse per accepted press / repeat (registered)
//   btn_release  out  4  one-cycle pulse per accepted release (registered)
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 25,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_raw,
    output logic [3:0] btn_state,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_HELD       = 2'd2,
        ST_DB_RELEASE = 2'd3
    } btn_st_e;

    // Pin level that means "not pressed"; sync flops reset to it so a button
    // held through reset is seen as a fresh press afterwards.
    localparam logic [3:0]       RELEASED_LVL = ACTIVE_LOW ? 4'b1111 : 4'b0000;
    // Counters are compared before incrementing, so they stop at DB_LAST.
    localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic [3:0]       sync1_r;
    logic [3:0]       sync2_r;
    logic [3:0]       pressed_s;

    btn_st_e          state_r [4];
    btn_st_e          state_s [4];
    logic [CNT_W-1:0] cnt_r   [4];
    logic [CNT_W-1:0] cnt_s   [4];

    logic [3:0]       press_s;
    logic [3:0]       release_s;
    logic [3:0]       held_s;

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 32'd1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 32'd1);

    logic [CNT_W-1:0] rcnt_r [4];
    logic [CNT_W-1:0] rcnt_s [4];
    // 0 = waiting for the initial delay, 1 = periodic repeating
    logic [3:0]       rphase_r;
    logic [3:0]       rphase_s;
`endif

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= RELEASED_LVL;
            sync2_r <= RELEASED_LVL;
        end else begin
            sync1_r <= key_raw;
            sync2_r <= sync1_r;
        end
    end

    // Normalise to 1 = pressed regardless of pin polarity.
    always_comb begin
        if (ACTIVE_LOW) begin
            pressed_s = ~sync2_r;
        end else begin
            pressed_s = sync2_r;
        end
    end

    // Per-button debounce FSM: next state, counter and event pulses.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_s[i]   = state_r[i];
            cnt_s[i]     = cnt_r[i];
            press_s[i]   = 1'b0;
            release_s[i] = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rcnt_s[i]    = rcnt_r[i];
            rphase_s[i]  = rphase_r[i];
`endif
            case (state_r[i])
                ST_IDLE: begin
                    if (pressed_s[i]) begin
                        state_s[i] = ST_DB_PRESS;
                        cnt_s[i]   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s[i]   = {CNT_W{1'b0}};
                    end
                end
                ST_DB_PRESS: begin
                    if (!pressed_s[i]) begin
                        state_s[i] = ST_IDLE;
                        cnt_s[i]   = {CNT_W{1'b0}};
                    end else if (cnt_r[i] == DB_LAST) begin
                        state_s[i] = ST_HELD;
                        cnt_s[i]   = {CNT_W{1'b0}};
                        press_s[i] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                        // Only a genuinely new press restarts the repeat timing.
                        rcnt_s[i]   = {CNT_W{1'b0}};
                        rphase_s[i] = 1'b0;
`endif
                    end else begin
                        cnt_s[i]   = cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_HELD: begin
                    if (!pressed_s[i]) begin
                        state_s[i] = ST_DB_RELEASE;
                        cnt_s[i]   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s[i]   = {CNT_W{1'b0}};
`ifdef BTN_AUTO_REPEAT_EN
                        if ((!rphase_r[i] && (rcnt_r[i] == RD_LAST)) ||
                            ( rphase_r[i] && (rcnt_r[i] == RP_LAST))) begin
                            press_s[i]  = 1'b1;
                            rcnt_s[i]   = {CNT_W{1'b0}};
                            rphase_s[i] = 1'b1;
                        end else begin
                            rcnt_s[i]   = rcnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
`endif
                    end
                end
                ST_DB_RELEASE: begin
                    // Repeat counter is left untouched here so a bounced
                    // release resumes repeat timing where it was.
                    if (pressed_s[i]) begin
                        state_s[i]   = ST_HELD;
                        cnt_s[i]     = {CNT_W{1'b0}};
                    end else if (cnt_r[i] == DB_LAST) begin
                        state_s[i]   = ST_IDLE;
                        cnt_s[i]     = {CNT_W{1'b0}};
                        release_s[i] = 1'b1;
                    end else begin
                        cnt_s[i]     = cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_s[i] = ST_IDLE;
                    cnt_s[i]   = {CNT_W{1'b0}};
                end
            endcase
            held_s[i] = (state_s[i] == ST_HELD) || (state_s[i] == ST_DB_RELEASE);
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state_r[i] <= ST_IDLE;
                cnt_r[i]   <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_r[i] <= state_s[i];
                cnt_r[i]   <= cnt_s[i];
            end
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    // Auto-repeat counter and phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                rcnt_r[i] <= {CNT_W{1'b0}};
            end
            rphase_r <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                rcnt_r[i] <= rcnt_s[i];
            end
            rphase_r <= rphase_s;
        end
    end
`endif

    // Registered outputs, computed from the next state so level and pulse
    // change on the same edge as the accepting transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_state   <= 4'b0000;
            btn_press   <= 4'b0000;
            btn_release <= 4'b0000;
        end else begin
            btn_state   <= held_s;
            btn_press   <= press_s;
            btn_release <= release_s;
        end
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions the four raw push-button inputs into the clean `btn_state[3:0]` vector consumed by the bottom button bar renderer. The same outputs drive game logic.
- Per button: 2-flop synchroniser, counter-based debouncer, one-cycle press/release event pulses.
- Bit mapping is fixed: bit0 = right, bit1 = left, bit2 = up/flap, bit3 = spare.

Parameters:
- DEBOUNCE_CYCLES, 1000000, stable cycles required to accept a level change (20 ms at 50 MHz); legal range 1 to 2^CNT_W-1.
- CNT_W, 25, width of each per-button counter.
- ACTIVE_LOW, 1, 1 means raw input 0 = pressed; 0 means raw input 1 = pressed.
- REPEAT_DELAY, 25000000, held cycles before the first auto-repeat pulse (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 5000000, cycles between auto-repeat pulses (used only with AUTO_REPEAT_EN).

Ports:
- clk  input  1  system clock (single clock domain).
- rst  input  1  synchronous, active-high reset.
- key_raw  input  4  asynchronous raw button pins, polarity per ACTIVE_LOW.
- btn_state  output  4  debounced level, 1 = held; feeds the bar renderer's `btn_state`.
- btn_press  output  4  one-cycle pulse per accepted press (plus repeats if enabled).
- btn_release  output  4  one-cycle pulse per accepted release.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - On reset: all outputs 0, all counters 0, every FSM in IDLE, sync flops loaded with the released level.
  - A button already held when rst deasserts is seen as a fresh press after full debounce.
- Synchroniser: key_raw passes through two flops, then is normalised to p (1 = pressed).
- Per-button FSM, 4 independent instances:
  - IDLE:
    - p=1: go to DB_PRESS, cnt=0.
  - DB_PRESS:
    - p=0: go to IDLE, cnt=0 (glitch rejected, no pulse).
    - p=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD, btn_press=1 for one cycle.
    - otherwise: cnt++.
  - HELD:
    - p=0: go to DB_RELEASE, cnt=0.
  - DB_RELEASE:
    - p=1: go to HELD, cnt=0 (no pulse).
    - p=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE, btn_release=1 for one cycle.
    - otherwise: cnt++.
- btn_state = 1 in HELD or DB_RELEASE; 0 in IDLE or DB_PRESS. All outputs are registered.
- Latency:
  - Count the first clk edge that samples a new raw level as edge 0, with the raw level stable afterwards.
  - btn_state and the matching pulse change at edge DEBOUNCE_CYCLES+2.
  - btn_press and btn_state rise on the same edge; btn_release and btn_state fall on the same edge.
- A raw pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change.
- Buttons are fully independent: simultaneous presses yield simultaneous pulses, with no priority or masking.
- btn_press and btn_release of one bit are never high in the same cycle.
- Counters never wrap: cnt saturates by construction because it is compared before incrementing.
- rst asserted mid-debounce or mid-hold forces IDLE next edge, with no release pulse emitted.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined: each button has a second counter rcnt, cleared on entry to HELD.
  - While in HELD: after REPEAT_DELAY cycles, btn_press pulses once.
  - Then it pulses every REPEAT_PERIOD cycles while the button stays in HELD.
  - Entering DB_RELEASE freezes rcnt; returning to HELD from DB_RELEASE resumes without reset.
  - rcnt width is CNT_W.
- Undefined: no rcnt logic exists; exactly one btn_press per accepted press.

Test Plan:
- Basic press and release, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1:
  - Stimulus: drive key_raw[2]=0 from edge 0.
  - Required: btn_state[2] and btn_press[2] rise at edge 6; btn_press is high exactly 1 cycle.
  - Stimulus: release key_raw[2]=1 at edge 20.
  - Required: btn_state[2] falls and btn_release[2] pulses at edge 26.
- Glitch rejection, DEBOUNCE_CYCLES=4:
  - Stimulus: key_raw[0] low for 3 cycles, then high.
  - Required: btn_state, btn_press and btn_release all stay 0.
- Release bounce:
  - Stimulus: while held, key_raw[1] high for 2 cycles, then low again.
  - Required: btn_state[1] stays 1, no btn_release[1], no second btn_press[1].
- Simultaneous buttons:
  - Stimulus: key_raw=4'b1000 at edge 0 (bits 0-2 pressed together).
  - Required: btn_press=4'b0111 at edge 6 for 1 cycle, then btn_state=4'b0111.
- Reset mid-hold:
  - Stimulus: bit0 held with btn_state=4'b0001, rst=1 for 1 cycle, key still pressed.
  - Required: outputs 0 the edge after rst; no btn_release pulse; btn_press[0] re-fires 6 edges after rst deasserts.
- Auto-repeat, BTN_AUTO_REPEAT_EN defined, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3:
  - Stimulus: hold key_raw[2] from edge 0.
  - Required: btn_press[2] pulses at edges 6, 14, 17, 20 and so on.
  - Required without the macro: only the pulse at edge 6.
